// File: rtl/rom_array.sv
// Read-only 256x8 program/constant store for the toy processor.
// A case-based constant table feeds one registered output.
module rom_array #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] ADDR,
  output logic [DATA_WIDTH-1:0] DATA_OUT
);

  logic [DATA_WIDTH-1:0] data_d;
  logic [DATA_WIDTH-1:0] data_q;

  // Constant table; every address outside 0x00-0x0F reads zero.
  always_comb begin
    data_d = '0;
    case (ADDR)
      ADDR_WIDTH'(0):  data_d = DATA_WIDTH'(8'h81);
      ADDR_WIDTH'(1):  data_d = DATA_WIDTH'(8'h42);
      ADDR_WIDTH'(2):  data_d = DATA_WIDTH'(8'hC3);
      ADDR_WIDTH'(3):  data_d = DATA_WIDTH'(8'h24);
      ADDR_WIDTH'(4):  data_d = DATA_WIDTH'(8'hA5);
      ADDR_WIDTH'(5):  data_d = DATA_WIDTH'(8'h66);
      ADDR_WIDTH'(6):  data_d = DATA_WIDTH'(8'hE7);
      ADDR_WIDTH'(7):  data_d = DATA_WIDTH'(8'h18);
      ADDR_WIDTH'(8):  data_d = DATA_WIDTH'(8'h99);
      ADDR_WIDTH'(9):  data_d = DATA_WIDTH'(8'h5A);
      ADDR_WIDTH'(10): data_d = DATA_WIDTH'(8'hDB);
      ADDR_WIDTH'(11): data_d = DATA_WIDTH'(8'h3C);
      ADDR_WIDTH'(12): data_d = DATA_WIDTH'(8'hBD);
      ADDR_WIDTH'(13): data_d = DATA_WIDTH'(8'h7E);
      ADDR_WIDTH'(14): data_d = DATA_WIDTH'(8'hFF);
      ADDR_WIDTH'(15): data_d = DATA_WIDTH'(8'h00);
      default:         data_d = '0;
    endcase
  end

  // Output register; reset wins over a read on the same edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign DATA_OUT = data_q;

endmodule

// File: tb/tb_rom_array.sv
// Directed, table-driven bench for rom_array: reset, latency, hold,
// boundary, mid-stream reset, glitch immunity and a full address sweep.
module tb_rom_array;

  logic       clk;
  logic       rst;
  logic [7:0] addr;
  logic [7:0] data_out;

  int total;
  int bad;

  typedef struct {
    logic       rst;
    logic [7:0] addr;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] lo_tbl [0:15];

  rom_array #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .CLK      (clk),
    .RST      (rst),
    .ADDR     (addr),
    .DATA_OUT (data_out)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  function automatic logic [7:0] ref_byte(input logic [7:0] a);
    if (a < 8'd16) return lo_tbl[a[3:0]];
    return 8'h00;
  endfunction

  task automatic check(input string name, input logic [7:0] exp);
    total++;
    if (data_out !== exp) begin
      bad++;
      $display("FAIL %s: addr=%02h rst=%0b got=%02h want=%02h", name, addr, rst, data_out, exp);
    end
  endtask

  // Drive at the falling edge, let one rising edge pass, sample 1 ns after.
  task automatic step(input logic r, input logic [7:0] a, input logic [7:0] exp, input string name);
    @(negedge clk);
    rst  = r;
    addr = a;
    @(posedge clk);
    #1;
    check(name, exp);
  endtask

  initial begin
    lo_tbl = '{8'h81, 8'h42, 8'hC3, 8'h24, 8'hA5, 8'h66, 8'hE7, 8'h18,
               8'h99, 8'h5A, 8'hDB, 8'h3C, 8'hBD, 8'h7E, 8'hFF, 8'h00};
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    addr  = 8'h05;

    vecs.push_back('{1'b1, 8'h05, 8'h00, "reset_edge1"});
    vecs.push_back('{1'b1, 8'h05, 8'h00, "reset_edge2"});
    vecs.push_back('{1'b0, 8'h05, 8'h66, "release_05"});
    vecs.push_back('{1'b0, 8'h00, 8'h81, "latency_00"});
    vecs.push_back('{1'b0, 8'h01, 8'h42, "latency_01"});
    for (int i = 0; i < 5; i++)
      vecs.push_back('{1'b0, 8'h0A, 8'hDB, "hold_0a"});
    vecs.push_back('{1'b0, 8'hFF, 8'h00, "boundary_ff"});
    vecs.push_back('{1'b0, 8'h00, 8'h81, "wrap_00"});
    vecs.push_back('{1'b0, 8'h0E, 8'hFF, "addr_0e"});
    vecs.push_back('{1'b0, 8'h0F, 8'h00, "addr_0f"});
    vecs.push_back('{1'b0, 8'h10, 8'h00, "addr_10"});
    vecs.push_back('{1'b0, 8'h07, 8'h18, "addr_07"});
    vecs.push_back('{1'b1, 8'h0E, 8'h00, "reset_prio"});
    vecs.push_back('{1'b0, 8'h0D, 8'h7E, "after_reset_0d"});

    foreach (vecs[i]) step(vecs[i].rst, vecs[i].addr, vecs[i].exp, vecs[i].name);

    // Output must hold steady until the next rising edge.
    step(1'b0, 8'h0C, 8'hBD, "pre_hold_0c");
    @(negedge clk);
    addr = 8'h02;
    #20;
    check("hold_between_edges", 8'hBD);

    // A glitch on ADDR between edges must not reach DATA_OUT.
    addr = 8'h06;
    #10;
    addr = 8'h02;
    @(posedge clk);
    #1;
    check("glitch_ignored", 8'hC3);

    // Full sweep with a reset injected at address 0x03.
    for (int a = 0; a < 256; a++) begin
      if (a == 3) step(1'b1, 8'(a), 8'h00, "sweep_reset_03");
      else        step(1'b0, 8'(a), ref_byte(8'(a)), "sweep");
    end
    step(1'b0, 8'h03, 8'h24, "sweep_revisit_03");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
